// File: rtl/jtcontra_muldiv_seq.sv
// Bus-master sequencer for the 007452 multiply/divide peripheral: writes the
// operands, waits the compute latency, reads the result bytes back.
module jtcontra_muldiv_seq #(
  parameter int MUL_WAIT = 2,
  parameter int DIV_WAIT = 18
) (
  input  logic        rst,
  input  logic        clk,
  input  logic        req,
  input  logic        op,
  input  logic [15:0] opa,
  input  logic [15:0] opb,
  output logic        busy,
  output logic        done,
  output logic [15:0] res_lo,
  output logic [15:0] res_hi,
  output logic        cs,
  output logic        wrn,
  output logic [2:0]  addr,
  output logic [7:0]  dout,
  input  logic [7:0]  din
);

  localparam int WMAX = (MUL_WAIT > DIV_WAIT) ? MUL_WAIT : DIV_WAIT;
  localparam int CW   = (WMAX > 1) ? $clog2(WMAX) : 1;
  localparam logic [CW-1:0] MUL_LOAD = CW'((MUL_WAIT > 0) ? MUL_WAIT - 1 : 0);
  localparam logic [CW-1:0] DIV_LOAD = CW'((DIV_WAIT > 0) ? DIV_WAIT - 1 : 0);

  typedef enum logic [2:0] {IDLE, WRITE, WAIT, RD_ADDR, RD_CAP, DONE} state_t;

  state_t         state;
  logic           op_q;
  logic [15:0]    opa_q, opb_q;
  logic [1:0]     idx;
  logic [CW-1:0]  cnt;
  logic [31:0]    shadow, shadow_nxt;
  logic           last, wait_zero;

  function automatic logic [2:0] wr_addr(input logic o, input logic [1:0] i);
    return o ? 3'd2 + {1'b0, i} : {2'b00, i[0]};
  endfunction

  function automatic logic [7:0] wr_data(input logic o, input logic [1:0] i,
                                         input logic [15:0] a, input logic [15:0] b);
    logic [7:0] d;
    d = 8'h00;
    if (!o) d = i[0] ? b[7:0] : {1'b0, a[6:0]};
    else case (i)
      2'd0:    d = b[15:8];
      2'd1:    d = b[7:0];
      2'd2:    d = a[15:8];
      default: d = a[7:0];
    endcase
    return d;
  endfunction

  // Divide reads quotient first (4,5) then remainder (2,3), so byte slot
  // idx of the shadow register maps straight onto {res_hi, res_lo}.
  function automatic logic [2:0] rd_addr(input logic o, input logic [1:0] i);
    if (!o) return {2'b00, i[0]};
    return i[1] ? 3'd2 + {2'b00, i[0]} : 3'd4 + {2'b00, i[0]};
  endfunction

  assign last      = op_q ? (idx == 2'd3) : (idx == 2'd1);
  assign wait_zero = op_q ? (DIV_WAIT == 0) : (MUL_WAIT == 0);

  always_comb begin
    shadow_nxt = shadow;
    case (idx)
      2'd0:    shadow_nxt[7:0]   = din;
      2'd1:    shadow_nxt[15:8]  = din;
      2'd2:    shadow_nxt[23:16] = din;
      default: shadow_nxt[31:24] = din;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      busy   <= 1'b0;
      done   <= 1'b0;
      res_lo <= 16'h0000;
      res_hi <= 16'h0000;
      cs     <= 1'b0;
      wrn    <= 1'b1;
      addr   <= 3'd0;
      dout   <= 8'h00;
      op_q   <= 1'b0;
      opa_q  <= 16'h0000;
      opb_q  <= 16'h0000;
      idx    <= 2'd0;
      cnt    <= '0;
      shadow <= 32'h0;
    end else begin
      done <= 1'b0;
      cs   <= 1'b0;
      wrn  <= 1'b1;
      case (state)
        IDLE, DONE: begin
          state <= IDLE;
          if (req) begin
            state  <= WRITE;
            busy   <= 1'b1;
            op_q   <= op;
            opa_q  <= opa;
            opb_q  <= opb;
            idx    <= 2'd0;
            shadow <= 32'h0;
            cs     <= 1'b1;
            wrn    <= 1'b0;
            addr   <= wr_addr(op, 2'd0);
            dout   <= wr_data(op, 2'd0, opa, opb);
          end
        end
        WRITE: begin
          if (last) begin
            idx <= 2'd0;
            if (wait_zero) begin
              state <= RD_ADDR;
              cs    <= 1'b1;
              addr  <= rd_addr(op_q, 2'd0);
            end else begin
              state <= WAIT;
              cnt   <= op_q ? DIV_LOAD : MUL_LOAD;
            end
          end else begin
            idx  <= idx + 2'd1;
            cs   <= 1'b1;
            wrn  <= 1'b0;
            addr <= wr_addr(op_q, idx + 2'd1);
            dout <= wr_data(op_q, idx + 2'd1, opa_q, opb_q);
          end
        end
        WAIT: begin
          if (cnt == '0) begin
            state <= RD_ADDR;
            cs    <= 1'b1;
            addr  <= rd_addr(op_q, 2'd0);
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        RD_ADDR: begin
          // address held a second cycle for the peripheral's registered read
          state <= RD_CAP;
          cs    <= 1'b1;
        end
        RD_CAP: begin
          shadow <= shadow_nxt;
          if (last) begin
            state  <= DONE;
            busy   <= 1'b0;
            done   <= 1'b1;
            res_lo <= shadow_nxt[15:0];
            res_hi <= op_q ? shadow_nxt[31:16] : 16'h0000;
          end else begin
            state <= RD_ADDR;
            idx   <= idx + 2'd1;
            cs    <= 1'b1;
            addr  <= rd_addr(op_q, idx + 2'd1);
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_jtcontra_muldiv_seq.sv
// Scoreboard bench for jtcontra_muldiv_seq with a behavioural 007452 model.
module tb_jtcontra_muldiv_seq;

  logic        rst, clk, req, op;
  logic [15:0] opa, opb;
  logic        busy, done, cs, wrn;
  logic [15:0] res_lo, res_hi;
  logic [2:0]  addr;
  logic [7:0]  dout, din;

  jtcontra_muldiv_seq dut (
    .rst(rst), .clk(clk), .req(req), .op(op), .opa(opa), .opb(opb),
    .busy(busy), .done(done), .res_lo(res_lo), .res_hi(res_hi),
    .cs(cs), .wrn(wrn), .addr(addr), .dout(dout), .din(din)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Peripheral model: zero divisor reports quotient 0xFFFF, remainder = dividend
  logic [6:0]  fa;
  logic [7:0]  fb;
  logic [15:0] dvs, dvd, quo, rem, prod;
  assign prod = {9'd0, fa} * {8'd0, fb};

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      fa <= '0; fb <= '0; dvs <= '0; dvd <= '0; quo <= '0; rem <= '0; din <= '0;
    end else if (cs && !wrn) begin
      case (addr)
        3'd0: fa <= dout[6:0];
        3'd1: fb <= dout;
        3'd2: dvs[15:8] <= dout;
        3'd3: dvs[7:0] <= dout;
        3'd4: dvd[15:8] <= dout;
        3'd5: begin
          if (dvs == 16'h0) begin
            quo <= 16'hFFFF;
            rem <= {dvd[15:8], dout};
          end else begin
            quo <= {dvd[15:8], dout} / dvs;
            rem <= {dvd[15:8], dout} % dvs;
          end
        end
        default: ;
      endcase
    end else if (cs && wrn) begin
      case (addr)
        3'd0: din <= prod[7:0];
        3'd1: din <= prod[15:8];
        3'd2: din <= rem[7:0];
        3'd3: din <= rem[15:8];
        3'd4: din <= quo[7:0];
        3'd5: din <= quo[15:8];
        default: din <= 8'h00;
      endcase
    end
  end

  typedef struct { logic [2:0] a; logic [7:0] d; } wr_t;
  typedef struct { logic [15:0] lo; logic [15:0] hi; int bc; int rc; } res_t;
  wr_t  exp_wr[$];
  res_t exp_res[$];

  int n_cmp = 0, n_bad = 0;
  int bcnt = 0, rcnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: bus writes and results popped against the expectation queues
  always @(negedge clk) begin
    if (rst) begin
      bcnt = 0;
      rcnt = 0;
    end else begin
      if (busy) bcnt++;
      if (cs && wrn) rcnt++;
      if (cs && !wrn) begin
        if (exp_wr.size() == 0) chk("bus_wr_unexpected", {addr, dout}, 32'hFFFF_FFFF);
        else begin
          wr_t w;
          w = exp_wr.pop_front();
          chk("bus_wr", {21'd0, addr, dout}, {21'd0, w.a, w.d});
        end
      end
      if (done) begin
        if (exp_res.size() == 0) chk("done_unexpected", {16'd0, res_lo}, 32'hFFFF_FFFF);
        else begin
          res_t r;
          r = exp_res.pop_front();
          chk("res_lo", {16'd0, res_lo}, {16'd0, r.lo});
          chk("res_hi", {16'd0, res_hi}, {16'd0, r.hi});
          chk("busy_cycles", bcnt, r.bc);
          chk("read_cycles", rcnt, r.rc);
        end
        bcnt = 0;
        rcnt = 0;
      end
    end
  end

  task automatic expect_cmd(input logic o, input logic [7:0] w0, input logic [7:0] w1,
                            input logic [7:0] w2, input logic [7:0] w3,
                            input logic [15:0] lo, input logic [15:0] hi);
    if (!o) begin
      exp_wr.push_back('{3'd0, w0});
      exp_wr.push_back('{3'd1, w1});
      exp_res.push_back('{lo, hi, 8, 4});
    end else begin
      exp_wr.push_back('{3'd2, w0});
      exp_wr.push_back('{3'd3, w1});
      exp_wr.push_back('{3'd4, w2});
      exp_wr.push_back('{3'd5, w3});
      exp_res.push_back('{lo, hi, 30, 8});
    end
  endtask

  // Operands are scrambled right after the accepting edge to prove they were latched
  task automatic issue(input logic o, input logic [15:0] a, input logic [15:0] b,
                       input logic [7:0] w0, input logic [7:0] w1,
                       input logic [7:0] w2, input logic [7:0] w3,
                       input logic [15:0] lo, input logic [15:0] hi);
    @(negedge clk);
    op = o; opa = a; opb = b; req = 1'b1;
    expect_cmd(o, w0, w1, w2, w3, lo, hi);
    @(posedge clk);
    #1;
    req = 1'b0; op = ~o; opa = 16'hDEAD; opb = 16'hBEEF;
  endtask

  task automatic wait_idle(input string name);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      #1;
      if (exp_res.size() == 0 && !busy) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) chk({name, "_timeout"}, 32'd0, 32'd1);
  endtask

  initial begin
    rst = 1'b1; req = 1'b0; op = 1'b0; opa = 16'h0; opb = 16'h0;
    #3;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_res", {res_hi, res_lo}, 32'd0);
    chk("rst_bus", {20'd0, cs, wrn, addr, dout}, {20'd0, 1'b0, 1'b1, 3'd0, 8'h00});
    repeat (2) @(negedge clk);
    #2 rst = 1'b0;

    issue(1'b0, 16'h007F, 16'h00FF, 8'h7F, 8'hFF, 8'h00, 8'h00, 16'h7E81, 16'h0000);
    wait_idle("mul_7f_ff");
    issue(1'b0, 16'h00FF, 16'h0003, 8'h7F, 8'h03, 8'h00, 8'h00, 16'h017D, 16'h0000);
    wait_idle("mul_bit7");
    issue(1'b1, 16'h03E8, 16'h0007, 8'h00, 8'h07, 8'h03, 8'hE8, 16'h008E, 16'h0006);
    wait_idle("div_1000_7");
    issue(1'b1, 16'h1234, 16'h0000, 8'h00, 8'h00, 8'h12, 8'h34, 16'hFFFF, 16'h1234);
    wait_idle("div_zero");

    // req pulses while busy must be ignored
    issue(1'b0, 16'h0012, 16'h0034, 8'h12, 8'h34, 8'h00, 8'h00, 16'h03A8, 16'h0000);
    repeat (2) @(negedge clk);
    req = 1'b1; op = 1'b1; opa = 16'h5555; opb = 16'h0003;
    @(negedge clk);
    req = 1'b0;
    @(negedge clk);
    req = 1'b1;
    @(negedge clk);
    req = 1'b0;
    wait_idle("mul_ignore_req");
    repeat (5) @(negedge clk);
    chk("idle_after_ignore", {30'd0, busy, cs}, 32'd0);

    // back-to-back: req held through DONE starts the next command with no gap
    issue(1'b0, 16'h0005, 16'h0006, 8'h05, 8'h06, 8'h00, 8'h00, 16'h001E, 16'h0000);
    op = 1'b1; opa = 16'hFFFF; opb = 16'h0100; req = 1'b1;
    expect_cmd(1'b1, 8'h01, 8'h00, 8'hFF, 8'hFF, 16'h00FF, 16'h00FF);
    begin
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < 100; i++) begin
        @(negedge clk);
        if (done) begin
          seen = 1'b1;
          break;
        end
      end
      if (!seen) chk("b2b_done_timeout", 32'd0, 32'd1);
    end
    @(posedge clk);
    #1;
    req = 1'b0; opa = 16'hDEAD; opb = 16'hBEEF; op = 1'b0;
    chk("b2b_no_gap_busy", {31'd0, busy}, 32'd1);
    chk("b2b_no_gap_wr", {31'd0, cs && !wrn}, 32'd1);
    wait_idle("b2b");

    // reset during the divide wait aborts the command
    issue(1'b1, 16'h0064, 16'h000A, 8'h00, 8'h0A, 8'h00, 8'h64, 16'h000A, 16'h0000);
    repeat (8) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("abort_cs", {31'd0, cs}, 32'd0);
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_res", {res_hi, res_lo}, 32'd0);
    chk("abort_writes_done", exp_wr.size(), 32'd0);
    if (exp_res.size() > 0) void'(exp_res.pop_back());
    @(negedge clk);
    #2 rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("abort_idle", {30'd0, busy, done}, 32'd0);
    issue(1'b1, 16'h0064, 16'h000A, 8'h00, 8'h0A, 8'h00, 8'h64, 16'h000A, 16'h0000);
    wait_idle("div_after_abort");

    repeat (4) @(negedge clk);
    chk("final_wr_queue", exp_wr.size(), 32'd0);
    chk("final_res_queue", exp_res.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
